// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared writeback constants and the writeback-source type.
package rv_wb_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = $clog2(NREG);

    // Which requester owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_MEM
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: two valid/ready sources, load-issue notification and the RegFile write port.
interface regfile_wb_arbiter_if;
    import rv_wb_pkg::*;

    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;

    logic            mem_valid;
    logic [AW-1:0]   mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            mem_ready;

    logic            issue_en;
    logic [AW-1:0]   issue_rd;

    logic            wb_en;
    logic [AW-1:0]   rd_index;
    logic [XLEN-1:0] wb_data;
    logic [NREG-1:0] pending;

    // Pipeline side: drives requests, observes grants and the write port.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output issue_en, issue_rd,
        input  alu_ready, mem_ready,
        input  wb_en, rd_index, wb_data, pending
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  issue_en, issue_rd,
        output alu_ready, mem_ready,
        output wb_en, rd_index, wb_data, pending
    );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Per-register load-pending scoreboard. A set and clear of the same register in one
// cycle leaves it set, since the set belongs to a younger load still in flight.
module regfile_scoreboard
    import rv_wb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_en_i,
    input  logic [AW-1:0]   set_idx_i,
    input  logic            clr_en_i,
    input  logic [AW-1:0]   clr_idx_i,
    output logic [NREG-1:0] pending_o
);

    logic [NREG-1:0] pending_q, pending_d;

    // Next pending vector: clear first so a same-cycle set overrides it; x0 never pends.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) begin
            pending_d[clr_idx_i] = 1'b0;
        end
        if (set_en_i) begin
            pending_d[set_idx_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Scoreboard state with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between ALU writeback and load return, with
// WAW stall against outstanding loads and bounded ALU starvation.
module regfile_wb_arbiter
    import rv_wb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_wb_arbiter_if.slave bus
);

    localparam int unsigned CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] StarveLimit = CW'(STARVE_MAX);

    logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
    logic            wb_en_q, wb_en_d;
    logic [AW-1:0]   rd_index_q, rd_index_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [NREG-1:0] pending;
    wb_src_e         grant;
    logic            alu_ok;
    logic            alu_hs;
    logic            mem_hs;

    // ALU may only compete when its destination has no load outstanding.
    assign alu_ok = bus.alu_valid && !pending[bus.alu_rd];

    // Grant: mem by default, ALU when mem is idle or ALU has lost STARVE_MAX times in a row.
    always_comb begin
        grant = WB_NONE;
        if (bus.mem_valid && !((starve_cnt_q == StarveLimit) && alu_ok)) begin
            grant = WB_MEM;
        end else if (alu_ok) begin
            grant = WB_ALU;
        end
    end

    // Handshakes are suppressed while reset is asserted so nothing appears accepted.
    assign alu_hs        = rst_n && (grant == WB_ALU);
    assign mem_hs        = rst_n && (grant == WB_MEM);
    assign bus.alu_ready = alu_hs;
    assign bus.mem_ready = mem_hs;

    // Starvation counter: only an eligible ALU that loses to mem counts.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (alu_hs) begin
            starve_cnt_d = '0;
        end else if (alu_ok && mem_hs && (starve_cnt_q != StarveLimit)) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end
    end

    // Output stage: one-cycle latency, x0 writes complete but never enable the RegFile.
    always_comb begin
        wb_en_d    = 1'b0;
        rd_index_d = rd_index_q;
        wb_data_d  = wb_data_q;
        if (alu_hs) begin
            wb_en_d    = (bus.alu_rd != '0);
            rd_index_d = bus.alu_rd;
            wb_data_d  = bus.alu_data;
        end else if (mem_hs) begin
            wb_en_d    = (bus.mem_rd != '0);
            rd_index_d = bus.mem_rd;
            wb_data_d  = bus.mem_data;
        end
    end

    // Arbiter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            wb_en_q      <= 1'b0;
            rd_index_q   <= '0;
            wb_data_q    <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            wb_en_q      <= wb_en_d;
            rd_index_q   <= rd_index_d;
            wb_data_q    <= wb_data_d;
        end
    end

    regfile_scoreboard u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en_i  (bus.issue_en),
        .set_idx_i (bus.issue_rd),
        .clr_en_i  (mem_hs),
        .clr_idx_i (bus.mem_rd),
        .pending_o (pending)
    );

    assign bus.wb_en    = wb_en_q;
    assign bus.rd_index = rd_index_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.pending  = pending;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized scoreboard bench for regfile_wb_arbiter with a rule-level reference model.
module tb_regfile_wb_arbiter;

    logic clk;
    logic rst_n;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(
        .STARVE_MAX (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        all;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;

    // Reference model state.
    logic [31:0] pend_m;
    int          starve_m;
    logic        last_alu_rdy;
    logic        last_mem_rdy;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         input logic ie, input logic [4:0] ird);
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_rd    = mrd;
        bus.mem_data  = md;
        bus.issue_en  = ie;
        bus.issue_rd  = ird;
    endtask

    // One functional cycle: drive, check grants against the model, advance the model.
    task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         input logic ie, input logic [4:0] ird);
        bit   alu_ok, mem_win, alu_hs, mem_hs;
        exp_t e;
        @(negedge clk);
        rst_n = 1'b1;
        drive(av, ard, ad, mv, mrd, md, ie, ird);
        #1;
        alu_ok  = av && !pend_m[ard];
        mem_win = mv && !(starve_m == 4 && alu_ok);
        mem_hs  = mem_win;
        alu_hs  = !mem_win && alu_ok;
        check("pending", {32'h0, bus.pending}, {32'h0, pend_m});
        check("alu_ready", {63'h0, bus.alu_ready}, {63'h0, alu_hs});
        check("mem_ready", {63'h0, bus.mem_ready}, {63'h0, mem_hs});
        last_alu_rdy = bus.alu_ready;
        last_mem_rdy = bus.mem_ready;
        if (alu_hs) starve_m = 0;
        else if (alu_ok && mem_hs && starve_m < 4) starve_m++;
        if (mem_hs) pend_m[mrd] = 1'b0;
        if (ie && ird != 0) pend_m[ird] = 1'b1;
        e.en   = 1'b0;
        e.rd   = '0;
        e.data = '0;
        e.all  = 1'b0;
        if (alu_hs && ard != 0) begin
            e.en = 1'b1; e.rd = ard; e.data = ad;
        end else if (mem_hs && mrd != 0) begin
            e.en = 1'b1; e.rd = mrd; e.data = md;
        end
        exp_q.push_back(e);
    endtask

    // One reset cycle with arbitrary traffic present, which must all be discarded.
    task automatic reset_cycle();
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 5'd7, $urandom, 1'b1, 5'd7, $urandom, 1'b1, 5'd9);
        #1;
        pend_m   = '0;
        starve_m = 0;
        e.en = 1'b0; e.rd = '0; e.data = '0; e.all = 1'b1;
        exp_q.push_back(e);
    endtask

    // Monitor: pop one expectation per cycle and compare the registered write port.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wb_en", {63'h0, bus.wb_en}, {63'h0, e.en});
                if (e.en || e.all) begin
                    check("rd_index", {59'h0, bus.rd_index}, {59'h0, e.rd});
                    check("wb_data", {32'h0, bus.wb_data}, {32'h0, e.data});
                end
            end
        end
    end

    initial begin
        logic [5:0] alu_pat;
        int         hot;
        pend_m   = '0;
        starve_m = 0;
        rst_n    = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
        reset_cycle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // ALU alone.
        cycle(1, 5, 32'h1234, 0, 0, 0, 0, 0);
        check("t1_alu_ready", {63'h0, last_alu_rdy}, 64'h1);

        // Contention for 6 cycles: mem x4, ALU, mem.
        for (int i = 0; i < 6; i++) begin
            cycle(1, 9, 32'hA000 + i, 1, 10, 32'hB000 + i, 0, 0);
            alu_pat[i] = last_alu_rdy;
        end
        check("t2_alu_pattern", {58'h0, alu_pat}, 64'h10);

        // WAW stall on r7.
        cycle(0, 0, 0, 0, 0, 0, 1, 7);
        cycle(1, 7, 32'h77, 0, 0, 0, 0, 0);
        check("t3_stalled", {63'h0, last_alu_rdy}, 64'h0);
        cycle(1, 7, 32'h77, 0, 0, 0, 0, 0);
        cycle(1, 7, 32'h77, 1, 7, 32'hAA, 0, 0);
        check("t3_mem_first", {63'h0, last_mem_rdy}, 64'h1);
        cycle(1, 7, 32'h77, 0, 0, 0, 0, 0);
        check("t3_alu_after", {63'h0, last_alu_rdy}, 64'h1);

        // Set/clear clash on r3.
        cycle(0, 0, 0, 0, 0, 0, 1, 3);
        cycle(0, 0, 0, 1, 3, 32'h33, 1, 3);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        check("t4_pending3", {63'h0, bus.pending[3]}, 64'h1);
        cycle(0, 0, 0, 1, 3, 32'h34, 0, 0);

        // x0 writes and issues.
        cycle(1, 0, 32'hDEAD, 0, 0, 0, 0, 0);
        check("t5_x0_ready", {63'h0, last_alu_rdy}, 64'h1);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        check("t5_x0_pending", {32'h0, bus.pending}, 64'h0);

        // Reset mid-operation with r7 pending and starvation at 3.
        cycle(0, 0, 0, 0, 0, 0, 1, 7);
        for (int i = 0; i < 3; i++) cycle(1, 9, 32'hC0 + i, 1, 10, 32'hD0 + i, 0, 0);
        check("t6_pending_pre", {32'h0, bus.pending}, 64'h80);
        reset_cycle();
        cycle(1, 7, 32'h7777, 0, 0, 0, 0, 0);
        check("t6_alu_after_rst", {63'h0, last_alu_rdy}, 64'h1);

        // Randomized traffic over a small register window to force conflicts.
        for (int i = 0; i < 3000; i++) begin
            hot = (i % 1000 < 500) ? 8 : 3;
            if ($urandom_range(0, 199) == 0) begin
                reset_cycle();
            end else begin
                cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                      1'($urandom_range(0, 9) < hot), 5'($urandom_range(0, 7)), $urandom,
                      1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
            end
        end

        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
